// File: rtl/triangle_sched.sv
`timescale 1ns/1ps
// triangle_sched
// Frame-level scheduler for the rasterizer. On a frame start it walks the
// triangle-record RAM from address 0. For each record it waits out the RAM
// read latency, captures the A/B/C vertices, pulses the rasterizer valid,
// then waits for the rasterizer's last_out before advancing to the next
// address.
//
// Optional feature: define TRI_SCHED_CULL_EN to skip degenerate triangles
// (all three x equal, or all three y equal) and count them. When it is not
// defined, every triangle is issued and cull_count_out is tied to 0.
//
// Ports:
//   clk_in, rst_n_in       clock, asynchronous active-low reset
//   start_in               frame start pulse, sampled only in IDLE
//   count_in               triangles this frame, clamped to TRIANGLES
//   abort_in               synchronous abort back to IDLE (no done pulse)
//   rd_addr_out            RAM port-B read address
//   tri_data_in            RAM port-B data {A,B,C}, each vertex {x[9:0],y[9:0]}
//   rast_valid_out         one-cycle pulse to the rasterizer
//   rast_vertex_*_out      vertices, stable from the pulse until rast_last_in
//   rast_last_in           rasterizer last_out
//   tri_index_out          index of the triangle in flight
//   busy_out               high from accepted start until done/abort
//   frame_done_out         one-cycle pulse at frame completion
//   cull_count_out         degenerate triangles skipped this frame
//   state_dbg_out          current FSM state encoding
//
// Rasterizer handshake: rast_valid_out is a single-cycle pulse with no
// backpressure; the rasterizer signals completion with rast_last_in, which
// is only honoured while waiting for it (stale pulses elsewhere are dropped).
module triangle_sched #(
  parameter int TRIANGLES    = 72,
  parameter int ADDR_W       = $clog2(TRIANGLES),
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [ADDR_W:0]   count_in,
  input  logic              abort_in,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [59:0]       tri_data_in,
  output logic              rast_valid_out,
  output logic [19:0]       rast_vertex_a_out,
  output logic [19:0]       rast_vertex_b_out,
  output logic [19:0]       rast_vertex_c_out,
  input  logic              rast_last_in,
  output logic [ADDR_W-1:0] tri_index_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic [ADDR_W:0]   cull_count_out,
  output logic [2:0]        state_dbg_out
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [ADDR_W:0]  TRI_MAX = (ADDR_W + 1)'(TRIANGLES);
  localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_LAST = 3'd3,
    S_NEXT      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [19:0]       va_q, va_d, vb_q, vb_d, vc_q, vc_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   count_clamped;
  logic              is_last;

`ifdef TRI_SCHED_CULL_EN
  logic [ADDR_W:0]   cull_q, cull_d;
  logic              degenerate;

  // Judged on the live RAM data at the capture cycle.
  assign degenerate =
    ((tri_data_in[59:50] == tri_data_in[39:30]) && (tri_data_in[39:30] == tri_data_in[19:10])) ||
    ((tri_data_in[49:40] == tri_data_in[29:20]) && (tri_data_in[29:20] == tri_data_in[9:0]));
`endif

  assign count_clamped = (count_in > TRI_MAX) ? TRI_MAX : count_in;
  // count_q is at least 1 whenever this is consulted (outside IDLE).
  assign is_last = ({1'b0, index_q} == (count_q - CNT_ONE));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    count_d = count_q;
    index_d = index_q;
    va_d    = va_q;
    vb_d    = vb_q;
    vc_d    = vc_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef TRI_SCHED_CULL_EN
    cull_d  = cull_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          count_d = count_clamped;
          index_d = '0;
`ifdef TRI_SCHED_CULL_EN
          cull_d  = '0;
`endif
          if (count_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            lat_d   = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        // READ_LATENCY+1 cycles of settled address before sampling data.
        if (lat_q == LAT_END) begin
          va_d = tri_data_in[59:40];
          vb_d = tri_data_in[39:20];
          vc_d = tri_data_in[19:0];
`ifdef TRI_SCHED_CULL_EN
          if (degenerate) begin
            cull_d = cull_q + CNT_ONE;
            if (is_last) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_NEXT;
            end
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_ISSUE: begin
        valid_d = 1'b1;
        state_d = S_WAIT_LAST;
      end
      S_WAIT_LAST: begin
        if (rast_last_in) begin
          if (is_last) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        index_d = index_q + ADDR_W'(1);
        lat_d   = '0;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // Abort wins over everything outside IDLE; in IDLE it is a no-op so a
    // simultaneous start is still accepted.
    if (abort_in && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lat_q   <= '0;
      count_q <= '0;
      index_q <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      vc_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TRI_SCHED_CULL_EN
      cull_q  <= '0;
`endif
    end else begin
      lat_q   <= lat_d;
      count_q <= count_d;
      index_q <= index_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      vc_q    <= vc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TRI_SCHED_CULL_EN
      cull_q  <= cull_d;
`endif
    end
  end

  // The read address always tracks the index of the triangle in flight.
  assign rd_addr_out       = index_q;
  assign tri_index_out     = index_q;
  assign rast_valid_out    = valid_q;
  assign rast_vertex_a_out = va_q;
  assign rast_vertex_b_out = vb_q;
  assign rast_vertex_c_out = vc_q;
  assign busy_out          = busy_q;
  assign frame_done_out    = done_q;
  assign state_dbg_out     = state_q;
`ifdef TRI_SCHED_CULL_EN
  assign cull_count_out    = cull_q;
`else
  assign cull_count_out    = '0;
`endif

endmodule

// File: tb/tb_triangle_sched.sv
`timescale 1ns/1ps
// tb_triangle_sched
// Directed bench for triangle_sched. A timeline model derived from the
// scheduler's timing rules predicts, per cycle after a start, the valid
// pulses, busy/done, index/address, held vertices and cull count. A
// rasterizer responder answers each valid with last_out D cycles later and
// a latency-2 RAM model feeds records.
module tb_triangle_sched;
  localparam int TRI = 72;
  localparam int AW  = $clog2(TRI);
  localparam int D   = 6;
  localparam int HOR = 1200;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start_in = 1'b0;
  logic [AW:0]   count_in = '0;
  logic          abort_in = 1'b0;
  logic [AW-1:0] rd_addr_out;
  logic [59:0]   tri_data_in;
  logic          rast_valid_out;
  logic [19:0]   rast_vertex_a_out, rast_vertex_b_out, rast_vertex_c_out;
  logic          rast_last_in = 1'b0;
  logic [AW-1:0] tri_index_out;
  logic          busy_out, frame_done_out;
  logic [AW:0]   cull_count_out;
  logic [2:0]    state_dbg_out;

  triangle_sched #(.TRIANGLES(TRI), .READ_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .count_in(count_in),
    .abort_in(abort_in), .rd_addr_out(rd_addr_out), .tri_data_in(tri_data_in),
    .rast_valid_out(rast_valid_out), .rast_vertex_a_out(rast_vertex_a_out),
    .rast_vertex_b_out(rast_vertex_b_out), .rast_vertex_c_out(rast_vertex_c_out),
    .rast_last_in(rast_last_in), .tri_index_out(tri_index_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .cull_count_out(cull_count_out),
    .state_dbg_out(state_dbg_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_in = ~clk_in;

  int edge_cnt = 0;
  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  // ---------------- RAM model (address to data: 2 cycles) ----------------
  logic [59:0] mem [TRI];
  logic [59:0] ram_p1 = '0, ram_p2 = '0;
  always @(posedge clk_in) begin
    ram_p1 <= (int'(rd_addr_out) < TRI) ? mem[int'(rd_addr_out)] : '0;
    ram_p2 <= ram_p1;
  end
  assign tri_data_in = ram_p2;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int base = 0;
  bit chk_en = 1'b0;
  int pending = -1;
  int spur_c = -1;
  int obs_pulses = 0;
  int obs_last_addr = -1;

  int e_valid[HOR], e_busy[HOR], e_done[HOR], e_idx[HOR], e_cull[HOR], e_rec[HOR];
  int m_done, m_first, m_pulses, m_hor;

  task automatic chk(input string name, input int rel, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s (rel cycle %0d): actual %0d, required %0d", name, rel, act, exp);
    end
  endtask

  function automatic logic [19:0] vtx(input int x, input int y);
    return {x[9:0], y[9:0]};
  endfunction

  function automatic logic [59:0] rec(input int ax, input int ay, input int bx,
                                      input int by, input int cx, input int cy);
    return {vtx(ax, ay), vtx(bx, by), vtx(cx, cy)};
  endfunction

  function automatic bit culled(input int i);
    logic [59:0] r;
    r = mem[i];
`ifdef TRI_SCHED_CULL_EN
    return ((r[59:50] == r[39:30]) && (r[39:30] == r[19:10])) ||
           ((r[49:40] == r[29:20]) && (r[29:20] == r[9:0]));
`else
    return (r == 60'd0) && 1'b0;
`endif
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < TRI; i++) mem[i] = rec(i, i + 1, i + 50, 2 * i, 3 * i, i + 7);
  endtask

  task automatic fill_std();
    for (int i = 0; i < 3; i++) mem[i] = rec(10, 10, 20, 10, 10, 20);
  endtask

  // Timeline model: FETCH of triangle i first visible in cycle f; valid at
  // f+4; last answered at k=v+D; next FETCH at k+2; done at k+1 for the
  // final one. A culled triangle goes straight on: next FETCH at f+4, or
  // done at f+3 when it is the final one.
  task automatic build_model(input int cnt_req, input int abort_c);
    int n, f, v, k, done_c, ncull;
    n = (cnt_req > TRI) ? TRI : cnt_req;
    for (int c = 0; c < HOR; c++) begin
      e_valid[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_rec[c] = -1;
      e_idx[c]  = (c >= 1) ? 0 : -1;
      e_cull[c] = (c >= 1) ? 0 : -1;
    end
    m_pulses = 0; m_first = -1; ncull = 0; done_c = 1; f = 1;
    for (int i = 0; i < n; i++) begin
      for (int c = f; c < HOR; c++) e_idx[c] = i;
      if (culled(i)) begin
        ncull++;
        for (int c = f + 3; c < HOR; c++) e_cull[c] = ncull;
        done_c = f + 3;
        f = f + 4;
      end else begin
        v = f + 4;
        e_valid[v] = 1;
        m_pulses++;
        if (m_first < 0) m_first = v;
        k = v + D;
        for (int c = v; c <= k; c++) e_rec[c] = i;
        done_c = k + 1;
        f = k + 2;
      end
    end
    e_done[done_c] = 1;
    for (int c = 1; c < done_c; c++) e_busy[c] = 1;
    m_done = done_c;
    if (abort_c > 0) begin
      for (int c = abort_c + 1; c < HOR; c++) begin
        e_valid[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        e_idx[c] = -1; e_rec[c] = -1; e_cull[c] = -1;
      end
      m_hor = abort_c + 10;
    end else begin
      m_hor = done_c + 4;
    end
  endtask

  // ---------------- rasterizer responder ----------------
  initial begin
    int rel;
    forever begin
      @(negedge clk_in);
      rel = edge_cnt - base;
      rast_last_in = (rel == pending) || (rel == spur_c);
      if (rast_valid_out) pending = rel + D;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_in) begin : cmp
    int rel;
    logic [59:0] r;
    if (chk_en) begin
      rel = edge_cnt - base;
      if (rel >= 1 && rel < HOR) begin
        chk("valid", rel, int'(rast_valid_out), e_valid[rel]);
        chk("busy", rel, int'(busy_out), e_busy[rel]);
        chk("frame_done", rel, int'(frame_done_out), e_done[rel]);
        if (e_idx[rel] >= 0) begin
          chk("rd_addr", rel, int'(rd_addr_out), e_idx[rel]);
          chk("tri_index", rel, int'(tri_index_out), e_idx[rel]);
        end
        if (e_cull[rel] >= 0) chk("cull_count", rel, int'(cull_count_out), e_cull[rel]);
        if (e_rec[rel] >= 0) begin
          r = mem[e_rec[rel]];
          chk("vertex_a", rel, int'(rast_vertex_a_out), int'(r[59:40]));
          chk("vertex_b", rel, int'(rast_vertex_b_out), int'(r[39:20]));
          chk("vertex_c", rel, int'(rast_vertex_c_out), int'(r[19:0]));
        end
      end
      if (rast_valid_out) begin
        obs_pulses++;
        obs_last_addr = int'(rd_addr_out);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_frame(input int cnt, input int spur, input int abort_c, input bit busy_starts);
    build_model(cnt, abort_c);
    pending = -1; spur_c = -1;
    obs_pulses = 0; obs_last_addr = -1;
    @(negedge clk_in);
    base = edge_cnt; pending = -1; spur_c = spur;
    start_in = 1'b1; count_in = cnt[AW:0];
    chk_en = 1'b1;
    for (int r = 1; r <= m_hor; r++) begin
      @(negedge clk_in);
      start_in = busy_starts && (r == 3 || r == 20 || r == 30);
      count_in = busy_starts ? (AW + 1)'(1) : cnt[AW:0];
      abort_in = (r == abort_c);
    end
    chk_en = 1'b0; start_in = 1'b0; abort_in = 1'b0;
  endtask

  initial begin
    fill_pattern();
    fill_std();
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_busy", 0, int'(busy_out), 0);
    chk("rst_valid", 0, int'(rast_valid_out), 0);
    chk("rst_done", 0, int'(frame_done_out), 0);
    chk("rst_addr", 0, int'(rd_addr_out), 0);
    chk("rst_vertex_a", 0, int'(rast_vertex_a_out), 0);
    chk("rst_cull", 0, int'(cull_count_out), 0);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Clean 3-triangle frame.
    run_frame(3, -1, 0, 1'b0);
    chk("model_first_valid", 0, m_first, 5);
    chk("model_done_cycle", 0, m_done, 36);
    chk("t1_pulses", 0, obs_pulses, 3);
    chk("t1_last_addr", 0, obs_last_addr, 2);

    // Empty frame.
    run_frame(0, -1, 0, 1'b0);
    chk("model_done_count0", 0, m_done, 1);
    chk("t0_pulses", 0, obs_pulses, 0);

    // Stale last_out in FETCH of triangle 1 and starts while busy.
    run_frame(3, 14, 0, 1'b1);
    chk("spur_done_cycle", 0, m_done, 36);
    chk("spur_pulses", 0, obs_pulses, 3);

    // Oversized count clamps to the RAM depth.
    fill_pattern();
    run_frame(100, -1, 0, 1'b0);
    chk("model_pulses_clamp", 0, m_pulses, 72);
    chk("model_done_clamp", 0, m_done, 864);
    chk("clamp_pulses", 0, obs_pulses, 72);
    chk("clamp_last_addr", 0, obs_last_addr, 71);

    // Async reset while fetching (vertices still hold record 71).
    fill_std();
    @(negedge clk_in);
    base = edge_cnt; start_in = 1'b1; count_in = (AW + 1)'(3);
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    chk("pre_rst_busy", 2, int'(busy_out), 1);
    chk("pre_rst_vertex_a", 2, int'(rast_vertex_a_out), int'(vtx(71, 72)));
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_busy", 2, int'(busy_out), 0);
    chk("arst_valid", 2, int'(rast_valid_out), 0);
    chk("arst_done", 2, int'(frame_done_out), 0);
    chk("arst_addr", 2, int'(rd_addr_out), 0);
    chk("arst_index", 2, int'(tri_index_out), 0);
    chk("arst_vertex_a", 2, int'(rast_vertex_a_out), 0);
    chk("arst_vertex_b", 2, int'(rast_vertex_b_out), 0);
    chk("arst_vertex_c", 2, int'(rast_vertex_c_out), 0);
    chk("arst_cull", 2, int'(cull_count_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Abort in WAIT_LAST of triangle 1, then a single-triangle frame.
    run_frame(3, -1, 19, 1'b0);
    chk("abort_pulses", 0, obs_pulses, 2);
    run_frame(1, -1, 0, 1'b0);
    chk("after_abort_done", 0, m_done, 12);
    chk("after_abort_pulses", 0, obs_pulses, 1);
    chk("after_abort_addr", 0, obs_last_addr, 0);

    // Degenerate middle record.
    mem[1] = rec(5, 5, 5, 9, 5, 30);
    run_frame(3, -1, 0, 1'b0);
`ifdef TRI_SCHED_CULL_EN
    chk("cull_model_done", 0, m_done, 28);
    chk("cull_pulses", 0, obs_pulses, 2);
    chk("cull_final", 0, int'(cull_count_out), 1);
`else
    chk("cull_model_done", 0, m_done, 36);
    chk("cull_pulses", 0, obs_pulses, 3);
    chk("cull_final", 0, int'(cull_count_out), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
